// File: rtl/wb_arbiter2_pkg.sv
// Shared definitions for the two-master Wishbone arbiter: FSM encoding and
// stall-timer counter width.
package wb_arbiter2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT0  = 2'd1,
    ST_GNT1  = 2'd2,
    ST_ABORT = 2'd3
  } arb_state_t;

  localparam int TMR_W = 16;

endpackage

// File: rtl/wb_stall_timer.sv
// Counts consecutive stalled bus cycles; hit flags the cycle in which the
// TIMEOUT-th consecutive stall is seen.
module wb_stall_timer
  import wb_arbiter2_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic stall,
  input  logic clr,
  output logic hit
);

  // cnt_r holds the number of stall cycles already completed, so the
  // TIMEOUT-th stall cycle is the one where cnt_r equals TIMEOUT-1.
  localparam logic [TMR_W-1:0] LIMIT = TMR_W'(TIMEOUT - 1);

  logic [TMR_W-1:0] cnt_r;

  // Consecutive stall counter, cleared whenever the stall run is broken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {TMR_W{1'b0}};
    end else if (clr || !stall) begin
      cnt_r <= {TMR_W{1'b0}};
    end else if (cnt_r != LIMIT) begin
      cnt_r <= cnt_r + TMR_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign hit = stall && !clr && (cnt_r == LIMIT);

endmodule

// File: rtl/wb_arbiter2.sv
// Round-robin two-master Wishbone arbiter with stall timeout and abort.
// Bus mux and grant FSM live here; stall counting is in wb_stall_timer.
module wb_arbiter2
  import wb_arbiter2_pkg::*;
#(
  parameter int ADR_W   = 14,
  parameter int DAT_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               m0_CYC,
  input  logic               m0_STB,
  input  logic               m0_WE,
  input  logic [ADR_W-1:0]   m0_ADR,
  input  logic [DAT_W-1:0]   m0_DAT_MOSI,
  input  logic [DAT_W/8-1:0] m0_SEL,
  output logic               m0_ACK,
  output logic               m0_ERR,
  output logic [DAT_W-1:0]   m0_DAT_MISO,
  input  logic               m1_CYC,
  input  logic               m1_STB,
  input  logic               m1_WE,
  input  logic [ADR_W-1:0]   m1_ADR,
  input  logic [DAT_W-1:0]   m1_DAT_MOSI,
  input  logic [DAT_W/8-1:0] m1_SEL,
  output logic               m1_ACK,
  output logic               m1_ERR,
  output logic [DAT_W-1:0]   m1_DAT_MISO,
  output logic               s_CYC,
  output logic               s_STB,
  output logic               s_WE,
  output logic [ADR_W-1:0]   s_ADR,
  output logic [DAT_W-1:0]   s_DAT_MOSI,
  output logic [DAT_W/8-1:0] s_SEL,
  input  logic               s_ACK,
  input  logic [DAT_W-1:0]   s_DAT_MISO,
  output logic               owner
);

  arb_state_t state_r;
  logic       owner_r;
  logic       stall_s;
  logic       clr_s;
  logic       hit_s;

  assign stall_s = s_CYC && s_STB && !s_ACK;
  assign clr_s   = (state_r != ST_GNT0) && (state_r != ST_GNT1);

  wb_stall_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .stall(stall_s),
    .clr  (clr_s),
    .hit  (hit_s)
  );

  // Slave-side request mux: follows the granted master, idle bus otherwise
  always_comb begin
    s_CYC      = 1'b0;
    s_STB      = 1'b0;
    s_WE       = 1'b0;
    s_ADR      = {ADR_W{1'b0}};
    s_DAT_MOSI = {DAT_W{1'b0}};
    s_SEL      = {(DAT_W/8){1'b0}};
    case (state_r)
      ST_GNT0: begin
        s_CYC      = m0_CYC;
        s_STB      = m0_STB;
        s_WE       = m0_WE;
        s_ADR      = m0_ADR;
        s_DAT_MOSI = m0_DAT_MOSI;
        s_SEL      = m0_SEL;
      end
      ST_GNT1: begin
        s_CYC      = m1_CYC;
        s_STB      = m1_STB;
        s_WE       = m1_WE;
        s_ADR      = m1_ADR;
        s_DAT_MOSI = m1_DAT_MOSI;
        s_SEL      = m1_SEL;
      end
      default: begin
        s_CYC = 1'b0;
      end
    endcase
  end

  // Response routing; hit already implies no ACK this cycle
  always_comb begin
    m0_ACK = 1'b0;
    m0_ERR = 1'b0;
    m1_ACK = 1'b0;
    m1_ERR = 1'b0;
    case (state_r)
      ST_GNT0: begin
        m0_ACK = s_ACK;
        m0_ERR = hit_s;
      end
      ST_GNT1: begin
        m1_ACK = s_ACK;
        m1_ERR = hit_s;
      end
      default: begin
        m0_ACK = 1'b0;
      end
    endcase
  end

  assign m0_DAT_MISO = s_DAT_MISO;
  assign m1_DAT_MISO = s_DAT_MISO;
  assign owner       = owner_r;

  // Grant FSM; owner_r remembers the last grant for round-robin and abort
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      owner_r <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (m0_CYC && (!m1_CYC || owner_r)) begin
            state_r <= ST_GNT0;
            owner_r <= 1'b0;
          end else if (m1_CYC) begin
            state_r <= ST_GNT1;
            owner_r <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_GNT0: begin
          if (hit_s) begin
            state_r <= ST_ABORT;
          end else if (!m0_CYC) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_GNT0;
          end
        end
        ST_GNT1: begin
          if (hit_s) begin
            state_r <= ST_ABORT;
          end else if (!m1_CYC) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_GNT1;
          end
        end
        ST_ABORT: begin
          if (owner_r ? !m1_CYC : !m0_CYC) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_ABORT;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed self-checking bench for wb_arbiter2 (TIMEOUT=8).
module tb_wb_arbiter2;

  localparam int ADR_W = 14;
  localparam int DAT_W = 32;
  localparam int SEL_W = DAT_W / 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             m0_CYC = 1'b0, m0_STB = 1'b0, m0_WE = 1'b0;
  logic [ADR_W-1:0] m0_ADR = '0;
  logic [DAT_W-1:0] m0_DAT_MOSI = '0;
  logic [SEL_W-1:0] m0_SEL = '0;
  logic             m0_ACK, m0_ERR;
  logic [DAT_W-1:0] m0_DAT_MISO;
  logic             m1_CYC = 1'b0, m1_STB = 1'b0, m1_WE = 1'b0;
  logic [ADR_W-1:0] m1_ADR = '0;
  logic [DAT_W-1:0] m1_DAT_MOSI = '0;
  logic [SEL_W-1:0] m1_SEL = '0;
  logic             m1_ACK, m1_ERR;
  logic [DAT_W-1:0] m1_DAT_MISO;
  logic             s_CYC, s_STB, s_WE;
  logic [ADR_W-1:0] s_ADR;
  logic [DAT_W-1:0] s_DAT_MOSI;
  logic [SEL_W-1:0] s_SEL;
  logic             s_ACK = 1'b0;
  logic [DAT_W-1:0] s_DAT_MISO = '0;
  logic             owner;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_arbiter2 #(.ADR_W(ADR_W), .DAT_W(DAT_W), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_CYC(m0_CYC), .m0_STB(m0_STB), .m0_WE(m0_WE), .m0_ADR(m0_ADR),
    .m0_DAT_MOSI(m0_DAT_MOSI), .m0_SEL(m0_SEL), .m0_ACK(m0_ACK),
    .m0_ERR(m0_ERR), .m0_DAT_MISO(m0_DAT_MISO),
    .m1_CYC(m1_CYC), .m1_STB(m1_STB), .m1_WE(m1_WE), .m1_ADR(m1_ADR),
    .m1_DAT_MOSI(m1_DAT_MOSI), .m1_SEL(m1_SEL), .m1_ACK(m1_ACK),
    .m1_ERR(m1_ERR), .m1_DAT_MISO(m1_DAT_MISO),
    .s_CYC(s_CYC), .s_STB(s_STB), .s_WE(s_WE), .s_ADR(s_ADR),
    .s_DAT_MOSI(s_DAT_MOSI), .s_SEL(s_SEL), .s_ACK(s_ACK),
    .s_DAT_MISO(s_DAT_MISO), .owner(owner)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic m0_req(input logic on);
    m0_CYC = on; m0_STB = on; m0_WE = 1'b1;
    m0_ADR = 14'h0010; m0_DAT_MOSI = 32'hA5A5_0001; m0_SEL = 4'hF;
  endtask

  task automatic m1_req(input logic on);
    m1_CYC = on; m1_STB = on; m1_WE = 1'b0;
    m1_ADR = 14'h0123; m1_DAT_MOSI = 32'h0; m1_SEL = 4'h3;
  endtask

  task automatic test_reset();
    checks++; if (s_CYC !== 1'b0) begin errors++; $display("FAIL reset_s_cyc: got %b want 0", s_CYC); end
    checks++; if (owner !== 1'b1) begin errors++; $display("FAIL reset_owner: got %b want 1", owner); end
    checks++; if ({m0_ACK, m0_ERR, m1_ACK, m1_ERR} !== 4'b0000) begin errors++; $display("FAIL reset_resp: got %b want 0000", {m0_ACK, m0_ERR, m1_ACK, m1_ERR}); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_write();
    m0_req(1'b1);
    #1;
    checks++; if (s_CYC !== 1'b0) begin errors++; $display("FAIL sw_latency: s_CYC got %b want 0", s_CYC); end
    tick();
    checks++; if (s_CYC !== 1'b1 || s_ADR !== 14'h0010 || s_DAT_MOSI !== 32'hA5A5_0001 || s_WE !== 1'b1)
      begin errors++; $display("FAIL sw_bus: cyc=%b adr=%h dat=%h we=%b want 1/0010/a5a50001/1", s_CYC, s_ADR, s_DAT_MOSI, s_WE); end
    checks++; if (owner !== 1'b0) begin errors++; $display("FAIL sw_owner: got %b want 0", owner); end
    checks++; if (m0_ACK !== 1'b0) begin errors++; $display("FAIL sw_early_ack: got %b want 0", m0_ACK); end
    tick();
    s_ACK = 1'b1; s_DAT_MISO = 32'h1234_5678;
    #1;
    checks++; if (m0_ACK !== 1'b1 || m1_ACK !== 1'b0 || m0_ERR !== 1'b0) begin errors++; $display("FAIL sw_ack: m0_ack=%b m1_ack=%b m0_err=%b want 1/0/0", m0_ACK, m1_ACK, m0_ERR); end
    checks++; if (m0_DAT_MISO !== 32'h1234_5678 || m1_DAT_MISO !== 32'h1234_5678) begin errors++; $display("FAIL sw_miso: got %h/%h want 12345678", m0_DAT_MISO, m1_DAT_MISO); end
    tick();
    s_ACK = 1'b0; m0_req(1'b0);
    tick();
    checks++; if (s_CYC !== 1'b0 || owner !== 1'b0) begin errors++; $display("FAIL sw_release: cyc=%b owner=%b want 0/0", s_CYC, owner); end
  endtask

  task automatic test_withdrawn();
    m1_req(1'b1);
    #2;
    m1_req(1'b0);
    tick();
    checks++; if (s_CYC !== 1'b0 || owner !== 1'b0) begin errors++; $display("FAIL withdrawn: cyc=%b owner=%b want 0/0", s_CYC, owner); end
  endtask

  task automatic test_round_robin();
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    m0_req(1'b1); m1_req(1'b1);
    tick();
    checks++; if (owner !== 1'b0 || s_ADR !== 14'h0010) begin errors++; $display("FAIL rr_first: owner=%b adr=%h want 0/0010", owner, s_ADR); end
    s_ACK = 1'b1;
    #1;
    checks++; if (m0_ACK !== 1'b1 || m1_ACK !== 1'b0) begin errors++; $display("FAIL rr_ack0: m0=%b m1=%b want 1/0", m0_ACK, m1_ACK); end
    tick();
    s_ACK = 1'b0; m0_req(1'b0);
    tick();
    checks++; if (s_CYC !== 1'b0 || owner !== 1'b0) begin errors++; $display("FAIL rr_idle_gap: cyc=%b owner=%b want 0/0", s_CYC, owner); end
    tick();
    checks++; if (owner !== 1'b1 || s_CYC !== 1'b1 || s_ADR !== 14'h0123 || s_WE !== 1'b0) begin errors++; $display("FAIL rr_second: owner=%b cyc=%b adr=%h we=%b want 1/1/0123/0", owner, s_CYC, s_ADR, s_WE); end
    s_ACK = 1'b1;
    #1;
    checks++; if (m1_ACK !== 1'b1 || m0_ACK !== 1'b0) begin errors++; $display("FAIL rr_ack1: m1=%b m0=%b want 1/0", m1_ACK, m0_ACK); end
    tick();
    s_ACK = 1'b0; m1_req(1'b0);
    tick();
  endtask

  task automatic test_multi_beat();
    m1_req(1'b1);
    tick();
    m0_req(1'b1);
    for (int i = 0; i < 4; i++) begin
      s_ACK = 1'b1;
      #1;
      checks++; if (m1_ACK !== 1'b1 || m0_ACK !== 1'b0 || owner !== 1'b1 || s_ADR !== 14'h0123)
        begin errors++; $display("FAIL mb_beat%0d: m1_ack=%b m0_ack=%b owner=%b adr=%h want 1/0/1/0123", i, m1_ACK, m0_ACK, owner, s_ADR); end
      tick();
    end
    s_ACK = 1'b0; m1_req(1'b0);
    tick();
    checks++; if (s_CYC !== 1'b0 || owner !== 1'b1) begin errors++; $display("FAIL mb_gap: cyc=%b owner=%b want 0/1", s_CYC, owner); end
    tick();
    checks++; if (owner !== 1'b0 || s_ADR !== 14'h0010) begin errors++; $display("FAIL mb_m0: owner=%b adr=%h want 0/0010", owner, s_ADR); end
    m0_req(1'b0);
    tick();
  endtask

  task automatic test_timeout();
    m0_req(1'b1);
    tick();
    for (int k = 1; k < 8; k++) begin
      checks++; if (m0_ERR !== 1'b0 || s_CYC !== 1'b1) begin errors++; $display("FAIL to_early%0d: err=%b cyc=%b want 0/1", k, m0_ERR, s_CYC); end
      tick();
    end
    checks++; if (m0_ERR !== 1'b1 || m0_ACK !== 1'b0 || m1_ERR !== 1'b0) begin errors++; $display("FAIL to_err: m0_err=%b m0_ack=%b m1_err=%b want 1/0/0", m0_ERR, m0_ACK, m1_ERR); end
    m1_req(1'b1);
    tick();
    checks++; if (s_CYC !== 1'b0 || m0_ERR !== 1'b0) begin errors++; $display("FAIL to_abort: cyc=%b err=%b want 0/0", s_CYC, m0_ERR); end
    tick(); tick();
    checks++; if (s_CYC !== 1'b0 || owner !== 1'b0) begin errors++; $display("FAIL to_hold: cyc=%b owner=%b want 0/0", s_CYC, owner); end
    m0_req(1'b0);
    tick();
    checks++; if (s_CYC !== 1'b0) begin errors++; $display("FAIL to_idle: cyc=%b want 0", s_CYC); end
    tick();
    checks++; if (s_CYC !== 1'b1 || owner !== 1'b1) begin errors++; $display("FAIL to_m1_after: cyc=%b owner=%b want 1/1", s_CYC, owner); end
    m1_req(1'b0);
    tick();
  endtask

  task automatic test_ack_at_timeout();
    m0_req(1'b1);
    tick();
    for (int k = 1; k < 8; k++) tick();
    s_ACK = 1'b1;
    #1;
    checks++; if (m0_ACK !== 1'b1 || m0_ERR !== 1'b0) begin errors++; $display("FAIL at_ack: ack=%b err=%b want 1/0", m0_ACK, m0_ERR); end
    tick();
    s_ACK = 1'b0;
    #1;
    checks++; if (s_CYC !== 1'b1 || m0_ERR !== 1'b0 || owner !== 1'b0) begin errors++; $display("FAIL at_noabort: cyc=%b err=%b owner=%b want 1/0/0", s_CYC, m0_ERR, owner); end
    m0_req(1'b0);
    tick();
  endtask

  task automatic test_reset_mid();
    m1_req(1'b1);
    tick();
    checks++; if (s_CYC !== 1'b1 || owner !== 1'b1) begin errors++; $display("FAIL rm_grant: cyc=%b owner=%b want 1/1", s_CYC, owner); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (s_CYC !== 1'b0 || m1_ERR !== 1'b0 || owner !== 1'b1) begin errors++; $display("FAIL rm_async: cyc=%b err=%b owner=%b want 0/0/1", s_CYC, m1_ERR, owner); end
    tick();
    rst_n = 1'b1;
    m0_req(1'b1);
    tick();
    checks++; if (owner !== 1'b0 || s_ADR !== 14'h0010) begin errors++; $display("FAIL rm_first: owner=%b adr=%h want 0/0010", owner, s_ADR); end
    m0_req(1'b0); m1_req(1'b0);
    tick();
  endtask

  initial begin
    tick(); tick();
    test_reset();
    test_single_write();
    test_withdrawn();
    test_round_robin();
    test_multi_beat();
    test_timeout();
    test_ack_at_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_arbiter2.md
WB_ARBITER2 -- requirements
Module: wb_arbiter2

Interface
REQ-001 SHALL have parameter ADR_W, default 14, Wishbone word-address width.
REQ-002 SHALL have parameter DAT_W, default 32, Wishbone data width; SEL width is DAT_W/8.
REQ-003 SHALL have parameter TIMEOUT, default 255, stall cycles before abort; legal range 1..65535.
REQ-004 SHALL have port clk  input  1  sole clock.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports m0_CYC, m0_STB, m0_WE  input  1 each  master 0 (host bridge) control.
REQ-007 SHALL have ports m0_ADR, m0_DAT_MOSI, m0_SEL  input  ADR_W, DAT_W, DAT_W/8  master 0 address, write data and byte enables.
REQ-008 SHALL have ports m0_ACK, m0_ERR  output  1 each; m0_DAT_MISO  output  DAT_W  master 0 response.
REQ-009 SHALL have port set m1_* identical to m0_*  master 1 (on-chip sequencer).
REQ-010 SHALL have ports s_CYC, s_STB, s_WE, s_ADR, s_DAT_MOSI, s_SEL  output  as master  to USB device core.
REQ-011 SHALL have ports s_ACK  input  1; s_DAT_MISO  input  DAT_W  slave response.
REQ-012 SHALL have port owner  output  1  current/last grant index (debug).

Function
REQ-013 SHALL implement FSM states IDLE, GNT0, GNT1, ABORT.
REQ-014 In IDLE with any mN_CYC=1, SHALL go to GNTn at the next edge; s_CYC asserts one cycle after request (1-cycle grant latency).
REQ-015 When both request in IDLE, SHALL grant the master not granted last (round-robin); after reset master 0 wins.
REQ-016 In GNTn, s_* outputs SHALL be combinational copies of mN_*; mN_ACK = s_ACK; other master's ACK/ERR = 0.
REQ-017 mN_DAT_MISO SHALL equal s_DAT_MISO for both masters at all times.
REQ-018 In IDLE and ABORT, s_CYC, s_STB, s_WE = 0 and s_ADR, s_DAT_MOSI, s_SEL = 0.
REQ-019 GNTn SHALL hold while mN_CYC=1 (multi-beat cycles not interrupted); mN_CYC=0 -> IDLE next edge; an IDLE cycle separates every ownership change.
REQ-020 SHALL count consecutive cycles with s_CYC & s_STB & !s_ACK in a 16-bit counter; cleared on ACK, on STB low, and in IDLE.
REQ-021 When counter reaches TIMEOUT, SHALL drive mN_ERR=1 for exactly that cycle, mN_ACK=0, and go to ABORT.
REQ-022 ACK arriving in the same cycle the counter reaches TIMEOUT SHALL win: normal ACK, no ERR, stay in GNTn.
REQ-023 ABORT SHALL hold until the aborted master drops CYC, then go to IDLE; the other master's request waits.
REQ-024 A request withdrawn (CYC low) before grant SHALL cause no bus activity.
REQ-025 owner SHALL update on entry to GNTn and hold its value in IDLE/ABORT.

Reset
REQ-026 On rst_n=0, asynchronously: state=IDLE, owner=1 (so master 0 wins first), counter=0; hence all s_* = 0, mN_ACK = mN_ERR = 0.
REQ-027 Reset asserted mid-transfer SHALL drop s_CYC immediately; no ERR generated.

Structure
REQ-028 Shared package SHALL hold the FSM state encoding (2-bit) and the TIMEOUT counter width constant.
REQ-029 SHALL instantiate one sub-module wb_stall_timer (counter, clear, hit output); mux and FSM stay in wb_arbiter2.

Verification
REQ-030 m0 single write ADR=0x0010 DAT=0xA5A5_0001, slave ACK 2 cycles later -> s_CYC 1 cycle after m0_CYC, m0_ACK pulse, m1_ACK=0, owner=0.
REQ-031 m0 and m1 request same cycle from reset -> m0 granted; after m0 CYC drops, 1 IDLE cycle, then m1 granted, owner=1.
REQ-032 m1 holds CYC over 4 ACKed beats while m0 requests -> m1 keeps bus all 4 beats; m0 granted only after m1 release.
REQ-033 TIMEOUT=8, slave never ACKs -> m0_ERR high exactly on 8th stall cycle, s_CYC=0 next cycle, ABORT until m0_CYC=0.
REQ-034 TIMEOUT=8, ACK on 8th stall cycle -> m0_ACK=1, m0_ERR=0, no ABORT.
REQ-035 rst_n pulled low during m1 read -> s_CYC=0 asynchronously; after release first grant goes to m0.
